hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_pkg.sv | 12 +
 rtl/hazard_pend_cnt.sv | 27 ++
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and types for the register hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int DEF_NREG  = 32;
    localparam int DEF_NSRC  = 2;
    localparam int DEF_CNT_W = 2;
    localparam int DEF_XLEN  = 32;

    // Pending-write counter at the default width.
    typedef logic [DEF_CNT_W-1:0] pend_cnt_t;

endpackage

// File: rtl/hazard_pend_cnt.sv
// Per-register pending-write counter: up on issue, down on writeback,
// cleared by flush. It holds at full scale and at zero.
module hazard_pend_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    // Flush wins over everything; simultaneous inc and dec cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: tracks outstanding writes per architectural register,
// stalls issue on RAW hazards or counter saturation, and bypasses
// writeback data straight to a waiting source when it is the last write.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int NSRC  = DEF_NSRC,
    parameter int CNT_W = DEF_CNT_W,
    parameter int XLEN  = DEF_XLEN,
    parameter int AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [NSRC*AW-1:0]   issue_rs,
    input  logic [NSRC-1:0]      issue_rs_used,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 issue_wen,
    output logic                 issue_ready,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush,
    output logic [NSRC-1:0]      fwd_hit,
    output logic [NSRC*XLEN-1:0] fwd_data,
    output logic                 busy,
    output logic                 err_underflow,
    output logic [31:0]          stall_cycles
);

    logic [CNT_W-1:0] pend [NREG];
    logic [NSRC-1:0]  hazard;
    logic             fire;

    assign fire    = issue_valid & issue_ready;
    // x0 is hard-wired and never has an outstanding write.
    assign pend[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_pend
        hazard_pend_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .inc   (fire & issue_wen & (issue_rd == AW'(r))),
            .dec   (wb_valid & (wb_rd == AW'(r))),
            .cnt   (pend[r])
        );
    end

    // Per-slot bypass and hazard; a bypass only counts when this writeback
    // retires the last outstanding write to that register.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        hazard   = '0;
        for (int i = 0; i < NSRC; i++) begin
            fwd_hit[i] = issue_rs_used[i]
                       & (issue_rs[i*AW +: AW] != '0)
                       & wb_valid
                       & (wb_rd == issue_rs[i*AW +: AW])
                       & (pend[issue_rs[i*AW +: AW]] == CNT_W'(1));
            if (fwd_hit[i]) fwd_data[i*XLEN +: XLEN] = wb_data;
            hazard[i] = issue_rs_used[i]
                      & (pend[issue_rs[i*AW +: AW]] != '0)
                      & ~fwd_hit[i];
        end
    end

    // Issue is independent of issue_valid; a full destination counter blocks it.
    always_comb begin
        issue_ready = ~(|hazard)
                    & ~(issue_wen & (issue_rd != '0) & (pend[issue_rd] == {CNT_W{1'b1}}))
                    & ~flush;
    end

    // Any register with an outstanding write.
    always_comb begin
        busy = 1'b0;
        for (int r = 1; r < NREG; r++) busy = busy | (pend[r] != '0);
    end

    // Sticky error for a writeback that had no matching outstanding write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_underflow <= 1'b0;
        end else if (wb_valid && (wb_rd != '0) && (pend[wb_rd] == '0)) begin
            err_underflow <= 1'b1;
        end
    end

    // Saturating count of cycles where an instruction waited; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (issue_valid && !issue_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus randomized traffic
// checked against a register-level reference model.
module tb_hazard_scoreboard;

    localparam int NREG = 32, NSRC = 2, CNT_W = 2, XLEN = 32, AW = 5;
    localparam int PMAX = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 issue_valid;
    logic [NSRC*AW-1:0]   issue_rs;
    logic [NSRC-1:0]      issue_rs_used;
    logic [AW-1:0]        issue_rd;
    logic                 issue_wen;
    logic                 issue_ready;
    logic                 wb_valid;
    logic [AW-1:0]        wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic                 flush;
    logic [NSRC-1:0]      fwd_hit;
    logic [NSRC*XLEN-1:0] fwd_data;
    logic                 busy;
    logic                 err_underflow;
    logic [31:0]          stall_cycles;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          m_pend [NREG];
    logic        m_err;
    logic [31:0] m_stall;

    hazard_scoreboard #(.NREG(NREG), .NSRC(NSRC), .CNT_W(CNT_W), .XLEN(XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rs_used (issue_rs_used),
        .issue_rd      (issue_rd),
        .issue_wen     (issue_wen),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .flush         (flush),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data),
        .busy          (busy),
        .err_underflow (err_underflow),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int src(int s);
        return int'(issue_rs[s*AW +: AW]);
    endfunction

    function automatic logic m_hit(int s);
        return issue_rs_used[s] && src(s) != 0 && wb_valid
            && int'(wb_rd) == src(s) && m_pend[src(s)] == 1;
    endfunction

    function automatic logic [NSRC-1:0] m_hits();
        logic [NSRC-1:0] h;
        for (int s = 0; s < NSRC; s++) h[s] = m_hit(s);
        return h;
    endfunction

    function automatic logic [NSRC*XLEN-1:0] m_fdata();
        logic [NSRC*XLEN-1:0] d = '0;
        for (int s = 0; s < NSRC; s++) if (m_hit(s)) d[s*XLEN +: XLEN] = wb_data;
        return d;
    endfunction

    function automatic logic m_ready();
        if (flush) return 1'b0;
        for (int s = 0; s < NSRC; s++)
            if (issue_rs_used[s] && m_pend[src(s)] != 0 && !m_hit(s)) return 1'b0;
        if (issue_wen && issue_rd != 0 && m_pend[issue_rd] == PMAX) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_busy();
        for (int r = 1; r < NREG; r++) if (m_pend[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) m_pend[r] = 0;
        m_err = 1'b0;
        m_stall = '0;
    endtask

    // Apply one clock edge of architectural behaviour to the model.
    task automatic model_edge();
        logic rdy = m_ready();
        logic fire = issue_valid && rdy;
        if (issue_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (wb_valid && wb_rd != 0 && m_pend[wb_rd] == 0) m_err = 1'b1;
        if (flush) begin
            for (int r = 0; r < NREG; r++) m_pend[r] = 0;
        end else if (fire && issue_wen && issue_rd != 0 && wb_valid && wb_rd == issue_rd) begin
            // same-register issue and writeback cancel
        end else begin
            if (fire && issue_wen && issue_rd != 0) m_pend[issue_rd]++;
            if (wb_valid && wb_rd != 0 && m_pend[wb_rd] > 0) m_pend[wb_rd]--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs = '0; issue_rs_used = '0; issue_rd = '0;
        issue_wen = 0; wb_valid = 0; wb_rd = '0; wb_data = '0; flush = 0;
    endtask

    task automatic set_issue(input int rs0, input int rs1, input logic [1:0] used,
                             input int rd, input logic wen);
        issue_valid = 1; issue_rs = {AW'(rs1), AW'(rs0)}; issue_rs_used = used;
        issue_rd = AW'(rd); issue_wen = wen;
    endtask

    task automatic set_wb(input int rd, input logic [31:0] d);
        wb_valid = 1; wb_rd = AW'(rd); wb_data = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst_n = 0;
        model_reset();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (fwd_hit !== '0 || fwd_data !== '0) begin n_fail++; $display("FAIL reset_fwd got %b/%h want 0", fwd_hit, fwd_data); end
        n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", issue_ready); end
        flush = 1; #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_flush got %b want 0", issue_ready); end
        n_cmp++; if (stall_cycles !== 32'd0 || err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_regs got %0d/%b want 0/0", stall_cycles, err_underflow); end
        flush = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_raw_bypass();
        logic [31:0] base;
        idle(); set_issue(0, 0, 2'b00, 5, 1); #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_first_ready got %b want 1", issue_ready); end
        tick();
        base = m_stall;
        idle(); set_issue(5, 0, 2'b01, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_ready cycle %0d got %b want 0", k, issue_ready); end
            tick();
        end
        n_cmp++; if (stall_cycles !== base + 32'd3) begin n_fail++; $display("FAIL raw_stall_count got %0d want %0d", stall_cycles, base + 3); end
        set_wb(5, 32'hDEADBEEF); #1;
        n_cmp++; if (fwd_hit !== 2'b01 || fwd_data[31:0] !== 32'hDEADBEEF || issue_ready !== 1'b1)
            begin n_fail++; $display("FAIL raw_bypass got hit=%b data=%h rdy=%b want 01/deadbeef/1", fwd_hit, fwd_data[31:0], issue_ready); end
        tick();
        idle(); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL raw_drained_busy got %b want 0", busy); end
    endtask

    task automatic test_double_pend();
        idle(); set_issue(0, 0, 2'b00, 7, 1); tick(); tick();
        idle(); set_issue(0, 7, 2'b10, 0, 0); set_wb(7, 32'h1111_2222); #1;
        n_cmp++; if (fwd_hit !== 2'b00 || issue_ready !== 1'b0) begin n_fail++; $display("FAIL dbl_first_wb got hit=%b rdy=%b want 00/0", fwd_hit, issue_ready); end
        tick();
        wb_data = 32'h3333_4444; #1;
        n_cmp++; if (fwd_hit !== 2'b10 || fwd_data[63:32] !== 32'h3333_4444 || issue_ready !== 1'b1)
            begin n_fail++; $display("FAIL dbl_second_wb got hit=%b data=%h rdy=%b want 10/33334444/1", fwd_hit, fwd_data[63:32], issue_ready); end
        tick();
    endtask

    task automatic test_saturate();
        idle(); set_issue(0, 0, 2'b00, 3, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_issue%0d got %b want 1", k, issue_ready); end
            tick();
        end
        #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_blocked got %b want 0", issue_ready); end
        tick();
        set_wb(3, 32'h0); #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_blocked_wb got %b want 0", issue_ready); end
        tick();
        wb_valid = 0; #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_unblocked got %b want 1", issue_ready); end
        tick();
        idle(); set_wb(3, 32'h0); tick(); tick(); tick();
        idle(); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_drained got %b want 0", busy); end
    endtask

    task automatic test_same_cycle();
        idle(); set_issue(0, 0, 2'b00, 9, 1); tick();
        set_wb(9, 32'h5); tick();
        idle(); #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL same_busy got %b want 1", busy); end
        set_issue(9, 0, 2'b01, 0, 0); #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL same_still_pending got %b want 0", issue_ready); end
        set_wb(9, 32'h77); #1;
        n_cmp++; if (fwd_hit !== 2'b01 || fwd_data[31:0] !== 32'h77) begin n_fail++; $display("FAIL same_pend_is_1 got %b/%h want 01/77", fwd_hit, fwd_data[31:0]); end
        tick();
    endtask

    task automatic test_flush();
        idle(); #1;
        n_cmp++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL flush_pre_err got %b want 0", err_underflow); end
        set_issue(0, 0, 2'b00, 4, 1); tick(); tick();
        idle(); flush = 1; issue_valid = 1; #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", issue_ready); end
        tick();
        idle(); set_wb(4, 32'h9); tick();
        idle(); #1;
        n_cmp++; if (err_underflow !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_late_wb got err=%b busy=%b want 1/0", err_underflow, busy); end
    endtask

    task automatic test_x0();
        idle(); set_issue(0, 0, 2'b11, 0, 1); set_wb(0, 32'hABCD); #1;
        n_cmp++; if (fwd_hit !== 2'b00 || fwd_data !== '0 || issue_ready !== 1'b1)
            begin n_fail++; $display("FAIL x0 got hit=%b data=%h rdy=%b want 00/0/1", fwd_hit, fwd_data, issue_ready); end
        tick();
        idle(); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy got %b want 0", busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                rst_n = 0; model_reset(); #1;
                n_cmp++; if (busy !== 1'b0 || err_underflow !== 1'b0 || stall_cycles !== 32'd0)
                    begin n_fail++; $display("FAIL rnd_midreset got busy=%b err=%b stall=%0d want 0/0/0", busy, err_underflow, stall_cycles); end
                @(negedge clk); rst_n = 1;
            end
            issue_valid   = ($urandom_range(0, 9) < 7);
            issue_rs      = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            issue_rs_used = 2'($urandom);
            issue_rd      = AW'($urandom_range(0, 7));
            issue_wen     = ($urandom_range(0, 9) < 6);
            wb_valid      = ($urandom_range(0, 1) == 1);
            wb_rd         = AW'($urandom_range(0, 7));
            wb_data       = $urandom;
            flush         = ($urandom_range(0, 39) == 0);
            #1;
            n_cmp++;
            if (issue_ready !== m_ready() || fwd_hit !== m_hits() || fwd_data !== m_fdata()
                || busy !== m_busy() || err_underflow !== m_err || stall_cycles !== m_stall) begin
                n_fail++;
                $display("FAIL rnd cycle %0d got rdy=%b hit=%b busy=%b err=%b stall=%0d want rdy=%b hit=%b busy=%b err=%b stall=%0d",
                         i, issue_ready, fwd_hit, busy, err_underflow, stall_cycles,
                         m_ready(), m_hits(), m_busy(), m_err, m_stall);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_raw_bypass();
        test_double_pend();
        test_saturate();
        test_same_cycle();
        test_x0();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
